// File: rtl/dmem_responder.sv
// Single-port data memory responder with a valid/ready request and response channel and a configurable wait latency.
// Build option: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word accesses with rsp_err.
module dmem_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state_o
);

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready,
  // a response on a rising edge with rsp_valid & rsp_ready; the responder holds
  // rsp_rdata/rsp_err stable while rsp_valid is high and ignores req_valid
  // whenever req_ready is low.

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [AW+1:0]   addr_q;
  logic            we_q;
  logic [2:0]      funct3_q;
  logic [31:0]     wdata_q;
  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   word_idx;
  logic [31:0]     cur_word;
  logic [7:0]      sel_byte;
  logic [15:0]     sel_half;
  logic            illegal_f3;
  logic            misaligned;
  logic            access_err;
  logic [31:0]     load_data;
  logic [3:0]      st_be;
  logic [31:0]     st_data;
  logic            do_access;
  logic            mem_we;
  logic            unused_addr_bits;

  // Upper address bits select nothing: the array wraps modulo DEPTH_WORDS.
  assign unused_addr_bits = ^req_addr[31:AW+2];

  assign word_idx = addr_q[AW+1:2];
  assign cur_word = mem_q[word_idx];
  assign sel_byte = cur_word[8*addr_q[1:0] +: 8];
  assign sel_half = addr_q[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    illegal_f3 = 1'b0;
    if (we_q) begin
      illegal_f3 = !(funct3_q inside {3'b000, 3'b001, 3'b010});
    end else begin
      illegal_f3 = !(funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign misaligned = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                      ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
`else
  // Lane selection only looks at addr[1] (half) or nothing (word), which
  // forces natural alignment without further logic.
  assign misaligned = 1'b0;
`endif

  assign access_err = illegal_f3 || misaligned;

  always_comb begin
    load_data = 32'd0;
    case (funct3_q)
      3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_data = cur_word;
      3'b100:  load_data = {24'd0, sel_byte};
      3'b101:  load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  always_comb begin
    st_be   = 4'b0000;
    st_data = wdata_q;
    case (funct3_q)
      3'b000: begin
        st_be   = 4'b0001 << addr_q[1:0];
        st_data = {4{wdata_q[7:0]}};
      end
      3'b001: begin
        st_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        st_data = {2{wdata_q[15:0]}};
      end
      3'b010: begin
        st_be   = 4'b1111;
        st_data = wdata_q;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = wdata_q;
      end
    endcase
  end

  assign do_access = (state_q == WAIT) && (cnt_q == 4'd0);
  // Reset on the commit edge abandons the store.
  assign mem_we    = do_access && we_q && !access_err && !reset;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          rdata_d = (we_q || access_err) ? 32'd0 : load_data;
          err_d   = access_err;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
          rdata_d = 32'd0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
      addr_q   <= '0;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (state_q == IDLE && req_valid) begin
        addr_q   <= req_addr[AW+1:0];
        we_q     <= req_we;
        funct3_q <= req_funct3;
        wdata_q  <= req_wdata;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && st_be[b]) begin
        mem_q[word_idx][8*b +: 8] <= st_data[8*b +: 8];
      end
    end
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder with LATENCY=1 and the default depth.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  dmem_responder #(.DEPTH_WORDS(4096), .LATENCY(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver: one full transaction, inputs driven and outputs sampled on negedges.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic [31:0] rdata,
                       output logic err, output int lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h10;
    repeat (2) @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_prio_state: got %0d expected 0", dbg_state); end
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got rdata %h err %b expected 00000000 0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_word;
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL sw_word: got rdata %h err %b lat %0d expected 00000000 0 2", rd, er, lat);
    end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2) begin
      errors++; $display("FAIL lw_word: got rdata %h err %b lat %0d expected deadbeef 0 2", rd, er, lat);
    end
  endtask

  task automatic test_byte;
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h10, 32'h0, rd, er, lat);
    issue(1'b1, 3'b000, 32'h13, 32'hFFFFFF80, rd, er, lat);
    issue(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFFFF80 || er !== 1'b0) begin errors++; $display("FAIL lb: got %h expected ffffff80", rd); end
    issue(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h expected 00000080", rd); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80000000) begin errors++; $display("FAIL lw_after_sb: got %h expected 80000000", rd); end
    issue(1'b0, 3'b100, 32'h12, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00000000) begin errors++; $display("FAIL lbu_neighbour: got %h expected 00000000", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h20, 32'h0, rd, er, lat);
    issue(1'b1, 3'b001, 32'h22, 32'h12348001, rd, er, lat);
    issue(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hFFFF8001 || er !== 1'b0) begin errors++; $display("FAIL lh: got %h expected ffff8001", rd); end
    issue(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu: got %h expected 00008001", rd); end
    issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80010000) begin errors++; $display("FAIL lw_after_sh: got %h expected 80010000", rd); end
  endtask

  task automatic test_stall;
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== 32'h80000000 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got valid %b ready %b rdata %h err %b expected 1 0 80000000 0",
                 i, rsp_valid, req_ready, rsp_rdata, rsp_err);
      end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0BADF00D;
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got ready %b valid %b expected 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin errors++; $display("FAIL stall_not_queued: got state %0d expected 0", dbg_state); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 3'b010, 32'h20, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80010000) begin errors++; $display("FAIL ignored_store: got %h expected 80010000", rd); end
  endtask

  task automatic test_illegal;
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL load_f3_011: got rdata %h err %b expected 00000000 1", rd, er); end
    issue(1'b1, 3'b100, 32'h10, 32'h11111111, rd, er, lat);
    checks++;
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL store_f3_100: got rdata %h err %b expected 00000000 1", rd, er); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80000000 || er !== 1'b0) begin errors++; $display("FAIL illegal_no_write: got %h expected 80000000", rd); end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic er; int lat;
    issue(1'b0, 3'b010, 32'h11, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lw_misaligned: got rdata %h err %b expected 00000000 1", rd, er); end
`else
    if (rd !== 32'h80000000 || er !== 1'b0) begin errors++; $display("FAIL lw_misaligned: got rdata %h err %b expected 80000000 0", rd, er); end
`endif
    issue(1'b0, 3'b001, 32'h13, 32'h0, rd, er, lat);
    checks++;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (rd !== 32'd0 || er !== 1'b1) begin errors++; $display("FAIL lh_misaligned: got rdata %h err %b expected 00000000 1", rd, er); end
`else
    if (rd !== 32'hFFFF8000 || er !== 1'b0) begin errors++; $display("FAIL lh_misaligned: got rdata %h err %b expected ffff8000 0", rd, er); end
`endif
  endtask

  task automatic test_wrap;
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h00004030, 32'hCAFEF00D, rd, er, lat);
    issue(1'b0, 3'b010, 32'h00000030, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_low: got %h expected cafef00d", rd); end
    issue(1'b0, 3'b010, 32'hFFFF0030, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hCAFEF00D) begin errors++; $display("FAIL wrap_high: got %h expected cafef00d", rd); end
  endtask

  task automatic test_reset_wait;
    logic [31:0] rd; logic er; int lat;
    issue(1'b1, 3'b010, 32'h40, 32'hA5A5A5A5, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h40; req_wdata = 32'h12345678;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    // Counter is now 0: the next edge would commit the store.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_in_wait: got ready %b valid %b expected 1 0", req_ready, rsp_valid);
    end
    issue(1'b0, 3'b010, 32'h40, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL reset_no_commit: got %h expected a5a5a5a5", rd); end
    issue(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
    checks++;
    if (rd !== 32'h80000000) begin errors++; $display("FAIL reset_keeps_mem: got %h expected 80000000", rd); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 32'd0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall();
    test_back_to_back();
    test_illegal();
    test_misalign();
    test_wrap();
    test_reset_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096, number of 32-bit words stored; index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-002 SHALL have parameter LATENCY, default 1, extra wait cycles per access (legal 0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_funct3  input  3  RV32I access size/sign code.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was illegal; no memory access performed.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP; req_ready = 1 only in IDLE, rsp_valid = 1 only in RESP.
REQ-016 SHALL accept a request on an edge with req_valid & req_ready, latch addr/we/funct3/wdata, and enter WAIT with counter = LATENCY.
REQ-017 In WAIT, SHALL decrement the counter each edge; on the edge with counter = 0, SHALL perform the memory access and enter RESP; rsp_valid therefore rises LATENCY+1 cycles after acceptance.
REQ-018 Loads SHALL decode funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; byte/half lane selected by addr[1:0]/addr[1]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-019 Stores SHALL decode funct3: 000 SB, 001 SH, 010 SW; SHALL write only the addressed bytes from wdata[7:0]/[15:0]/[31:0] via byte enables.
REQ-020 Any other funct3 for the given direction SHALL set rsp_err = 1, rsp_rdata = 0, and leave memory unchanged.
REQ-021 Addresses beyond DEPTH_WORDS SHALL wrap modulo DEPTH_WORDS; upper address bits are ignored.
REQ-022 In RESP, rsp_rdata and rsp_err SHALL remain stable until the edge with rsp_ready = 1, then return to IDLE; req_ready rises the following cycle (no same-cycle re-accept).
REQ-023 req_valid asserted outside IDLE SHALL be ignored and not queued.
REQ-024 A store followed by a load to the same word SHALL return the newly written data.

Reset
REQ-025 With reset high at an edge: state = IDLE, counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; req_ready = 1 in the first cycle after reset.
REQ-026 Reset during WAIT SHALL abandon the request, and an uncommitted store SHALL NOT be written; memory contents SHALL NOT be cleared by reset.
REQ-027 Reset SHALL take priority over a simultaneous request or response handshake.

Configuration
REQ-028 Macro DMEM_MISALIGN_CHECK_EN: when defined, a halfword access with addr[0] = 1 or a word access with addr[1:0] != 0 SHALL respond with rsp_err = 1 and no memory access.
REQ-029 When DMEM_MISALIGN_CHECK_EN is undefined, misaligned accesses SHALL force the low address bits to the natural alignment (half: addr[0] = 0; word: addr[1:0] = 0), complete normally, and rsp_err SHALL flag only illegal funct3.

Verification
REQ-030 LATENCY=1: SW 0xDEADBEEF @0x10 then LW @0x10 -> rdata 0xDEADBEEF, err 0, rsp_valid 2 cycles after each acceptance.
REQ-031 SB 0x80 @0x13 over word 0x00000000, then LB @0x13 -> 0xFFFFFF80; LBU @0x13 -> 0x00000080; LW @0x10 -> 0x80000000.
REQ-032 SH 0x8001 @0x22, then LH @0x22 -> 0xFFFF8001; LHU @0x22 -> 0x00008001.
REQ-033 rsp_ready held low 5 cycles with rsp_valid high -> rdata/err stable, req_ready low, extra req_valid ignored.
REQ-034 LW @0x11 -> with macro, err 1, rdata 0, memory unchanged; without macro, rdata = word @0x10, err 0; load funct3 011 -> err 1 in both builds.
REQ-035 Reset asserted in WAIT of SW 0x12345678 @0x40 -> next cycle req_ready 1, rsp_valid 0; later LW @0x40 returns the prior value.
